// File: rtl/mono_mode_ctrl.sv
// Frame-synchronous monochrome mode controller: merges button/hotkey/CPU requests
// into a pending target and commits it to `mode` at vsync start (or on timeout).
module mono_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned VS_TIMEOUT       = 2_000_000,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter logic [1:0]  RESET_MODE       = 2'b00
) (
  input  logic       CLK_50MHZ,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       kbd_cycle,
  input  logic       cpu_we,
  input  logic [1:0] cpu_mode,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       pending,
  output logic       mode_changed
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = (VS_TIMEOUT > 2) ? $clog2(VS_TIMEOUT) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(VS_TIMEOUT - 1);
  localparam logic VS_IDLE = VSYNC_ACTIVE_LOW;

  logic            r_btn_s1, r_btn_s2, r_b_stable, r_b_stable_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_vs_s1, r_vs_s2, r_vs_d, r_vs_evt;
  logic [TO_W-1:0] r_to_cnt;
  logic [1:0]      r_tgt, r_mode;
  logic            r_pending, r_mode_changed;

  logic            w_btn_evt, w_vs_edge, w_commit, w_adv;
  logic [1:0]      w_tgt_nxt;

  // Press event only: stable level going high->low
  assign w_btn_evt = r_b_stable_d & ~r_b_stable;
  assign w_vs_edge = (r_vs_s2 != VS_IDLE) & (r_vs_d == VS_IDLE);
  assign w_commit  = r_vs_evt | (r_to_cnt == TO_MAX);
  assign w_adv     = w_btn_evt | kbd_cycle;

  // The committed value equals r_tgt, so r_tgt is always the advance base
  always_comb begin
    w_tgt_nxt = r_tgt;
    if (cpu_we)     w_tgt_nxt = cpu_mode;
    else if (w_adv) w_tgt_nxt = r_tgt + 2'd1;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      r_btn_s1     <= 1'b1;
      r_btn_s2     <= 1'b1;
      r_b_stable   <= 1'b1;
      r_b_stable_d <= 1'b1;
      r_db_cnt     <= '0;
    end else begin
      r_btn_s1     <= btn_n;
      r_btn_s2     <= r_btn_s1;
      r_b_stable_d <= r_b_stable;
      if (r_btn_s2 == r_b_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_b_stable <= r_btn_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      r_vs_s1  <= VS_IDLE;
      r_vs_s2  <= VS_IDLE;
      r_vs_d   <= VS_IDLE;
      r_vs_evt <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_vs_s1  <= vsync;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
      r_vs_evt <= w_vs_edge;
      if (r_vs_evt || w_commit)  r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      r_tgt          <= RESET_MODE;
      r_mode         <= RESET_MODE;
      r_pending      <= 1'b0;
      r_mode_changed <= 1'b0;
    end else begin
      r_tgt          <= w_tgt_nxt;
      r_pending      <= (r_tgt != r_mode);
      r_mode_changed <= w_commit && (r_tgt != r_mode);
      if (w_commit) r_mode <= r_tgt;
    end
  end

  assign mode         = r_mode;
  assign pending      = r_pending;
  assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// Scoreboard bench: stimulus pushes expected committed modes, a monitor pops them
// on every mode_changed pulse; level checks cover pending and reset behaviour.
module tb_mono_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       kbd_cycle = 1'b0;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_mode = 2'b00;
  logic       vsync = 1'b1;
  logic [1:0] mode;
  logic       pending;
  logic       mode_changed;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  exp_q[$];
  logic        prev_mc = 1'b0;

  mono_mode_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .VS_TIMEOUT      (100),
    .VSYNC_ACTIVE_LOW(1'b1),
    .RESET_MODE      (2'b10)
  ) dut (
    .CLK_50MHZ   (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .kbd_cycle   (kbd_cycle),
    .cpu_we      (cpu_we),
    .cpu_mode    (cpu_mode),
    .vsync       (vsync),
    .mode        (mode),
    .pending     (pending),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each mode_changed pulse must match the oldest expected commit
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && mode_changed) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit got=%0h want=none t=%0t", mode, $time);
        end else begin
          e = exp_q.pop_front();
          chk("commit_mode", {30'd0, mode}, {30'd0, e});
        end
        if (prev_mc) begin
          checks++;
          errors++;
          $display("FAIL mode_changed_width got=2+ want=1 t=%0t", $time);
        end
      end
      prev_mc = mode_changed;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk) vsync = 1'b0;
    ticks(6);
    vsync = 1'b1;
    ticks(6);
  endtask

  task automatic kbd_strobe();
    @(negedge clk) kbd_cycle = 1'b1;
    @(negedge clk) kbd_cycle = 1'b0;
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mode", {30'd0, mode}, 32'h2);
    chk("reset_pending", {31'd0, pending}, 32'h0);
    chk("reset_mode_changed", {31'd0, mode_changed}, 32'h0);
    rst = 1'b0;
    ticks(3);

    // CPU write 00, commit on vsync
    @(negedge clk) begin cpu_we = 1'b1; cpu_mode = 2'b00; end
    @(negedge clk) cpu_we = 1'b0;
    ticks(2);
    chk("cpu_pending", {31'd0, pending}, 32'h1);
    exp_q.push_back(2'b00);
    vsync_pulse();
    chk("cpu_commit_pending", {31'd0, pending}, 32'h0);

    // Button held low 20 clocks -> advance 00->01, held until vsync
    @(negedge clk) btn_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) chk("btn_early_pending", {31'd0, pending}, 32'h0);
    end
    chk("btn_pending", {31'd0, pending}, 32'h1);
    chk("btn_mode_held", {30'd0, mode}, 32'h0);
    btn_n = 1'b1;
    exp_q.push_back(2'b01);
    vsync_pulse();
    chk("btn_commit_pending", {31'd0, pending}, 32'h0);

    // Bounce: 5-clock low pulses are rejected
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) btn_n = 1'b0;
      ticks(5);
      btn_n = 1'b1;
      ticks(5);
    end
    ticks(12);
    chk("bounce_pending", {31'd0, pending}, 32'h0);
    chk("bounce_mode", {30'd0, mode}, 32'h1);

    // Five hotkey strobes from 01: 10,11,00,01,10
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      kbd_strobe();
      ticks(1);
    end
    ticks(2);
    chk("kbd_pending", {31'd0, pending}, 32'h1);
    exp_q.push_back(2'b10);
    vsync_pulse();
    chk("kbd_commit_pending", {31'd0, pending}, 32'h0);

    // Priority: cpu_we beats kbd_cycle in the same clock
    vsync_pulse();
    @(negedge clk) begin cpu_we = 1'b1; cpu_mode = 2'b11; kbd_cycle = 1'b1; end
    @(negedge clk) begin cpu_we = 1'b0; kbd_cycle = 1'b0; end
    ticks(2);
    chk("prio_pending", {31'd0, pending}, 32'h1);
    exp_q.push_back(2'b11);
    // Hotkey lands exactly in the vs_evt cycle (3 clocks after the raw edge)
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) kbd_cycle = 1'b1;
    @(negedge clk) kbd_cycle = 1'b0;
    ticks(3);
    chk("vs_req_mode", {30'd0, mode}, 32'h3);
    chk("vs_req_pending", {31'd0, pending}, 32'h1);
    vsync = 1'b1;
    ticks(6);
    exp_q.push_back(2'b00);
    vsync_pulse();
    chk("vs_req_commit_pending", {31'd0, pending}, 32'h0);

    // Timeout commit with vsync static
    vsync_pulse();
    exp_q.push_back(2'b01);
    kbd_strobe();
    ticks(50);
    chk("to_pending_mid", {31'd0, pending}, 32'h1);
    chk("to_mode_mid", {30'd0, mode}, 32'h0);
    n = 0;
    while (exp_q.size() != 0 && n < 45) begin
      @(negedge clk);
      n++;
    end
    chk("to_commit_in_time", exp_q.size(), 32'h0);
    ticks(3);
    chk("to_pending_after", {31'd0, pending}, 32'h0);

    // Reset while a target is pending discards it
    vsync_pulse();
    kbd_strobe();
    kbd_strobe();
    ticks(3);
    chk("rst_pre_pending", {31'd0, pending}, 32'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mode", {30'd0, mode}, 32'h2);
    chk("rst_mid_pending", {31'd0, pending}, 32'h0);
    chk("rst_mid_mode_changed", {31'd0, mode_changed}, 32'h0);
    rst = 1'b0;
    ticks(5);
    vsync_pulse();
    ticks(110);
    chk("rst_post_pending", {31'd0, pending}, 32'h0);
    chk("rst_post_mode", {30'd0, mode}, 32'h2);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
